// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates fetch (I) and data (D) requesters onto one fixed-latency memory,
// flags unaligned accesses and pulses the memory dump on halt or first error.
module mem_arb_ctrl #(
    parameter int LAT = 0,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_stall,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_stall,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    input  logic          halt,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_dump,
    output logic          err
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_HALT} state_t;
    state_t        r_state;
    logic          r_own_d, r_wr, r_starve, r_i_done, r_d_done, r_mem_en, r_mem_wr, r_dump, r_err;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;
    logic          w_grant_d;
    logic [AW-1:0] w_addr;
    assign w_grant_d = d_req & (~i_req | ~r_starve);
    assign w_addr    = w_grant_d ? d_addr : i_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_own_d     <= 1'b0;
            r_wr        <= 1'b0;
            r_starve    <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_dump      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_dump      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (halt) begin
                        r_dump  <= 1'b1;
                        r_state <= S_HALT;
                    end else if (i_req | d_req) begin
                        r_own_d  <= w_grant_d;
                        r_wr     <= w_grant_d & d_wr;
                        // D wins ties unless I lost the previous tie
                        r_starve <= w_grant_d ? (r_starve | i_req) : (r_starve & ~d_req);
                        if (w_addr[0]) begin
                            r_err    <= 1'b1;
                            r_dump   <= ~r_err;
                            r_i_done <= ~w_grant_d;
                            r_d_done <= w_grant_d;
                            r_state  <= S_DONE;
                        end else begin
                            r_mem_en    <= 1'b1;
                            r_mem_wr    <= w_grant_d & d_wr;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_grant_d ? d_wdata : '0;
                            r_cnt       <= '0;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (r_cnt == 3'(LAT)) begin
                        if (!r_wr && r_own_d) r_d_rdata <= mem_rdata;
                        if (!r_wr && !r_own_d) r_i_rdata <= mem_rdata;
                        r_d_done <= r_own_d;
                        r_i_done <= ~r_own_d;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= S_WAIT;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_HALT;
            endcase
        end
    end
    assign i_stall   = i_req & ~r_i_done;
    assign d_stall   = d_req & ~r_d_done;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_dump  = r_dump;
    assign err       = r_err;
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: directed stimulus with a done-driven scoreboard for mem_arb_ctrl (LAT=2).
module tb_mem_arb_ctrl;
    localparam int LAT = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, halt = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_stall, i_done, d_stall, d_done, mem_en, mem_wr, mem_dump, err;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem [0:255];
    logic [15:0] pipe [0:LAT-1];
    int tests = 0, fails = 0, en_cnt = 0, dump_cnt = 0;
    typedef struct { bit is_d; logic [15:0] data; } exp_t;
    exp_t q[$];

    mem_arb_ctrl #(.LAT(LAT), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_done(d_done), .d_rdata(d_rdata),
        .halt(halt), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_dump(mem_dump), .err(err)
    );

    always #5 clk = ~clk;

    // fixed-latency memory: read data appears LAT cycles after the enable cycle
    always @(posedge clk) begin
        if (mem_en && mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
        pipe[0] <= mem[mem_addr[7:0]];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    always @(negedge clk) begin
        if (mem_en) en_cnt++;
        if (mem_dump) dump_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every completion must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && (i_done || d_done)) begin
            if (q.size() == 0) chk("unexpected_done", {i_done, d_done}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk(e.is_d ? "d_resp" : "i_resp", {i_done, d_done, (d_done ? d_rdata : i_rdata)},
                    {~e.is_d, e.is_d, e.data});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic wait_done(input bit is_d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_done : i_done) && n < 20);
        chk(is_d ? "d_done_seen" : "i_done_seen", is_d ? d_done : i_done, 1);
        step(1);
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic d_timed(input bit wr, input logic [15:0] a, input logic [15:0] w, input logic [15:0] exp);
        d_wr = wr; d_addr = a; d_wdata = w; d_req = 1'b1;
        q.push_back('{1'b1, exp});
        @(negedge clk);
        chk("idle_cycle", {d_stall, mem_en}, 2'b10);
        @(negedge clk);
        chk("issue_cycle", {mem_en, mem_wr, mem_addr, mem_wdata}, {1'b1, wr, a, w});
        repeat (LAT) begin
            @(negedge clk);
            chk("wait_cycle", {mem_en, d_done}, 0);
        end
        @(negedge clk);
        chk("d_done_latency", {d_done, d_stall}, 2'b10);
        step(1);
        d_req = 1'b0;
    endtask

    initial begin
        int bad, n, d0, e0;
        for (int k = 0; k < 256; k++) mem[k] = '0;
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
        #3;
        chk("reset_flags", {i_stall, i_done, d_stall, d_done, mem_en, mem_wr, mem_dump, err}, 0);
        chk("reset_data", {i_rdata, d_rdata, mem_addr, mem_wdata}, 0);
        step(1);
        rst = 1'b0;

        d_timed(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        d_timed(1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        // simultaneous requests: D first, I waits stalled
        i_addr = 16'h0010; i_req = 1'b1;
        d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234; d_req = 1'b1;
        q.push_back('{1'b1, 16'hBEEF});
        q.push_back('{1'b0, 16'hBEEF});
        bad = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!i_stall) bad++;
        end while (!d_done && n < 20);
        chk("i_stall_during_d", bad, 0);
        chk("d_first", {d_done, i_done}, 2'b10);
        step(1);
        d_req = 1'b0;
        wait_done(1'b0);

        // both held: strict alternation D,I,D,I
        do_reset();
        d_wr = 1'b0; d_addr = 16'h0020; i_addr = 16'h0010;
        q.push_back('{1'b1, 16'h1234});
        q.push_back('{1'b0, 16'hBEEF});
        q.push_back('{1'b1, 16'h1234});
        q.push_back('{1'b0, 16'hBEEF});
        d_req = 1'b1; i_req = 1'b1;
        bad = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (i_done || d_done) bad++;
        end while (bad < 4 && n < 60);
        step(1);
        d_req = 1'b0; i_req = 1'b0;
        step(3);
        chk("alt_all_served", {bad, q.size()}, {32'd4, 32'd0});

        // unaligned accesses
        d0 = dump_cnt; e0 = en_cnt;
        d_addr = 16'h0011; d_req = 1'b1;
        q.push_back('{1'b1, 16'h1234});
        @(negedge clk);
        chk("unaligned_idle", {mem_en, err}, 0);
        @(negedge clk);
        chk("unaligned_done", {d_done, err, mem_dump, mem_en}, 4'b1110);
        step(1);
        d_req = 1'b0;
        i_addr = 16'h0013; i_req = 1'b1;
        q.push_back('{1'b0, 16'hBEEF});
        wait_done(1'b0);
        step(3);
        chk("err_sticky", err, 1);
        chk("dump_once", dump_cnt - d0, 1);
        chk("unaligned_no_mem", en_cnt - e0, 0);

        // halt with idle bus
        do_reset();
        chk("err_cleared", err, 0);
        d0 = dump_cnt; e0 = en_cnt;
        halt = 1'b1;
        step(5);
        chk("halt_dump", dump_cnt - d0, 1);
        i_addr = 16'h0010; i_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("halted_stall", {i_stall, i_done}, 2'b10);
        step(1);
        chk("halted_no_mem", en_cnt - e0, 0);
        i_req = 1'b0; halt = 1'b0;

        // reset mid-WAIT abandons the access
        do_reset();
        i_addr = 16'h0010; i_req = 1'b1;
        q.push_back('{1'b0, 16'hBEEF});
        wait_done(1'b0);
        d_wr = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("midwait_rst_flags", {i_stall, i_done, d_stall, d_done, mem_en, mem_wr, mem_dump, err}, 0);
        chk("midwait_rst_data", {i_rdata, d_rdata, mem_addr, mem_wdata}, 0);
        step(1);
        rst = 1'b0;
        step(8);
        chk("no_orphan_done", q.size(), 0);
        d_timed(1'b0, 16'h0020, 16'h0000, 16'h1234);
        step(2);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
